// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : boot_loader
//  Purpose  : Loads a little-endian boot image (32-bit word-count header,
//             then payload words) into the SoC ROM/RAM word write port and
//             holds the core in reset until the image is complete.
//  Option   : BOOT_LOADER_CHECKSUM_EN adds a 4-byte mod-2**32 sum trailer.
//  Revision : 1.0 - initial release
// ============================================================================
module boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  // Largest legal word count: the full 2**ADDR_W address space.
  localparam logic [32:0]       CAP  = 33'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_SUM   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t      state, next_state;
  logic [1:0]  byte_idx;
  logic [31:0] word_q;
  logic [31:0] len_q;
  logic [31:0] full_word;
  logic        last_byte;
  logic        start_ok;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  // Word as it will look once the byte currently on the bus lands in lane 3.
  assign full_word = {in_byte, word_q[23:0]};
  assign last_byte = in_valid && (byte_idx == 2'd3);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  assign mem_wdata = word_q;
  assign mem_addr  = BASE + word_cnt[ADDR_W-1:0];

  // State, byte assembly, counters and the registered core reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_idx <= 2'd0;
      word_q   <= 32'd0;
      len_q    <= 32'd0;
      word_cnt <= '0;
      core_rst <= 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q    <= 32'd0;
`endif
    end else begin
      state    <= next_state;
      // Core leaves reset one cycle after DONE is entered.
      core_rst <= (state != S_DONE);
      if (start_ok) begin
        byte_idx <= 2'd0;
        word_cnt <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_q    <= 32'd0;
`endif
      end
      if (in_valid && in_ready) begin
        word_q[{byte_idx, 3'b000} +: 8] <= in_byte;
        byte_idx                        <= byte_idx + 2'd1;
      end
      if (state == S_HDR && last_byte) begin
        len_q <= full_word;
      end
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_q    <= sum_q + word_q;
`endif
      end
    end
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_HDR;
      end
      S_HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte) begin
          if (full_word == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            next_state = S_SUM;
`else
            next_state = S_DONE;
`endif
          end else if ({1'b0, full_word} > CAP) begin
            next_state = S_ERR;
          end else begin
            next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte) next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (32'(word_cnt) + 32'd1 < len_q) begin
          next_state = S_DATA;
        end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          next_state = S_SUM;
`else
          next_state = S_DONE;
`endif
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_SUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte) next_state = (full_word == sum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) next_state = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) next_state = S_HDR;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_loader
//  Purpose  : Directed self-checking bench for boot_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_byte = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_cnt;

  int checks = 0;
  int fails  = 0;
  bit stall_mode = 1'b0;
  int we_with_ready = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Record every write strobe as seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (in_ready) we_with_ready++;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (stall_mode) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_start();
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_trailer(input logic [31:0] s);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(s);
`else
    if (s == 32'hFFFF_FFFF) $display("unused trailer");
`endif
  endtask

  // Wait (bounded) for done or error; returns at the first such negedge.
  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      fails++;
      $display("FAIL wait_end_timeout: done=%0b error=%0b required one set", done, error);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({in_ready, mem_we, core_rst, busy, done, error} !== 6'b001000) begin
      fails++;
      $display("FAIL %s_flags: {rdy,we,crst,busy,done,err}=%b required 001000", tag,
               {in_ready, mem_we, core_rst, busy, done, error});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0 || word_cnt !== '0) begin
      fails++;
      $display("FAIL %s_values: addr=%h wdata=%h cnt=%0d required 0/0/0", tag,
               mem_addr, mem_wdata, word_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_idle");
  endtask

  task automatic check_three_words(input string tag);
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h0000_0093; exp_d[1] = 32'h0010_0113; exp_d[2] = 32'h0000_006F;
    checks++;
    if (wr_addr.size() != 3) begin
      fails++;
      $display("FAIL %s_count: writes=%0d required 3", tag, wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_d[i]) begin
          fails++;
          $display("FAIL %s_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                   tag, i, wr_addr[i], wr_data[i], i, exp_d[i]);
        end
      end
    end
  endtask

  task automatic send_three_word_image();
    send_word(32'd3);
    send_word(32'h0000_0093);
    send_word(32'h0010_0113);
    send_word(32'h0000_006F);
    send_trailer(32'h0010_0215);
  endtask

  task automatic test_basic();
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_hdr: busy=%0b in_ready=%0b required 1/1", busy, in_ready);
    end
    send_three_word_image();
    wait_end();
    check_three_words("basic");
    checks++;
    if (done !== 1'b1 || core_rst !== 1'b1 || word_cnt !== 11'd3) begin
      fails++;
      $display("FAIL basic_done_entry: done=%0b core_rst=%0b cnt=%0d required 1/1/3",
               done, core_rst, word_cnt);
    end
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL basic_core_release: core_rst=%0b done=%0b required 0/1", core_rst, done);
    end
  endtask

  task automatic test_stall();
    we_with_ready = 0;
    stall_mode = 1'b1;
    do_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stall_restart: done=%0b busy=%0b required 0/1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1) begin
      fails++;
      $display("FAIL stall_core_reassert: core_rst=%0b required 1", core_rst);
    end
    send_three_word_image();
    stall_mode = 1'b0;
    wait_end();
    check_three_words("stall");
    checks++;
    if (we_with_ready != 0 || done !== 1'b1) begin
      fails++;
      $display("FAIL stall_write_ready: we_with_ready=%0d done=%0b required 0/1",
               we_with_ready, done);
    end
  endtask

  task automatic test_zero_len();
    do_start();
    send_word(32'd0);
    send_trailer(32'd0);
    wait_end();
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || word_cnt !== '0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_len: done=%0b error=%0b cnt=%0d writes=%0d required 1/0/0/0",
               done, error, word_cnt, wr_addr.size());
    end
  endtask

  task automatic test_too_long();
    do_start();
    send_word(32'd1025);
    wait_end();
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL too_long: error=%0b done=%0b busy=%0b rdy=%0b required 1/0/0/0",
               error, done, busy, in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || error !== 1'b1 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL too_long_hold: core_rst=%0b error=%0b writes=%0d required 1/1/0",
               core_rst, error, wr_addr.size());
    end
  endtask

  task automatic test_rst_mid();
    do_start();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    send_trailer(32'hDEAD_BEEF);
    wait_end();
    checks++;
    if (wr_addr.size() != 1 || done !== 1'b1) begin
      fails++;
      $display("FAIL rst_restart_count: writes=%0d done=%0b required 1/1", wr_addr.size(), done);
    end else begin
      checks++;
      if (wr_addr[0] !== '0 || wr_data[0] !== 32'hDEAD_BEEF) begin
        fails++;
        $display("FAIL rst_restart_write: addr=%0d data=%h required 0/deadbeef",
                 wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_full();
    do_start();
    send_word(32'd1024);
    for (int i = 0; i < 1024; i++) send_word(32'(i));
    send_trailer(32'h0007_FE00);
    wait_end();
    checks++;
    if (wr_addr.size() != 1024 || done !== 1'b1 || word_cnt !== 11'd1024) begin
      fails++;
      $display("FAIL full_summary: writes=%0d done=%0b cnt=%0d required 1024/1/1024",
               wr_addr.size(), done, word_cnt);
    end else begin
      checks++;
      if (wr_addr[1023] !== 10'd1023 || wr_data[1023] !== 32'h0000_03FF ||
          wr_addr[512] !== 10'd512 || wr_data[512] !== 32'h0000_0200) begin
        fails++;
        $display("FAIL full_last: addr=%0d data=%h required 1023/000003ff",
                 wr_addr[1023], wr_data[1023]);
      end
    end
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    send_word(32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    wait_end();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL checksum_good: done=%0b error=%0b required 1/0", done, error);
    end
    do_start();
    send_word(32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd4);
    wait_end();
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || core_rst !== 1'b1) begin
      fails++;
      $display("FAIL checksum_bad: error=%0b done=%0b core_rst=%0b required 1/0/1",
               error, done, core_rst);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_too_long();
    test_rst_mid();
    test_full();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
